// File: rtl/float_divider.sv
// rtl/float_divider.sv - sequential 24-bit float divider, 18-step restoring mantissa division
module float_divider #(
   parameter int EXP_W = 7,
   parameter int MAN_W = 16,
   parameter int BIAS  = 63
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [EXP_W+MAN_W:0]     float_a,
   input  logic [EXP_W+MAN_W:0]     float_b,
   output logic                     busy,
   output logic                     done,
   output logic [EXP_W+MAN_W:0]     float_out,
   output logic                     float_out_overflow,
   output logic                     float_out_underflow,
   output logic                     float_out_div_by_zero
);

   localparam int W     = EXP_W + MAN_W + 1;
   localparam int CNT_W = $clog2(MAN_W + 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAN_W + 1);
   localparam logic [EXP_W+1:0] E_BIAS   = (EXP_W+2)'(BIAS);

   typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

   state_t             state, state_nxt;
   logic               sign;
   logic [EXP_W-1:0]   ea, eb;
   logic [MAN_W:0]     b_man;
   logic [MAN_W+1:0]   rem;
   logic [MAN_W+1:0]   q;
   logic [CNT_W-1:0]   cnt;

   logic               ge;
   logic [MAN_W+1:0]   rem_sub;
   logic [EXP_W+1:0]   e_calc;
   logic [MAN_W-1:0]   man_norm;
   logic [W-1:0]       res_word;
   logic               res_ov, res_uf, res_dz;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = DIV;
         DIV:     if (cnt == LAST_CNT) state_nxt = NORM;
         NORM:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ge      = (rem >= {1'b0, b_man});
      rem_sub = rem - {1'b0, b_man};
   end

   // q[MAN_W+1] is the integer bit; when clear the quotient is below 1 and needs one left shift.
   always_comb begin
      e_calc   = {2'b00, ea} - {2'b00, eb} + E_BIAS - {{(EXP_W+1){1'b0}}, ~q[MAN_W+1]};
      man_norm = q[MAN_W+1] ? q[MAN_W:1] : q[MAN_W-1:0];
      res_word = {sign, e_calc[EXP_W-1:0], man_norm};
      res_ov   = 1'b0;
      res_uf   = 1'b0;
      res_dz   = 1'b0;
      if (eb == '0) begin
         res_word = {sign, {(W-1){1'b1}}};
         res_ov   = 1'b1;
         res_dz   = 1'b1;
      end else if (ea == '0) begin
         res_word = {sign, {(W-1){1'b0}}};
      end else if (e_calc[EXP_W+1:EXP_W] == 2'b01) begin
         res_word = {sign, {(W-1){1'b1}}};
         res_ov   = 1'b1;
      end else if (e_calc[EXP_W+1] || e_calc == '0) begin
         res_word = {sign, {(W-1){1'b0}}};
         res_uf   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sign                  <= 1'b0;
         ea                    <= '0;
         eb                    <= '0;
         b_man                 <= '0;
         rem                   <= '0;
         q                     <= '0;
         cnt                   <= '0;
         busy                  <= 1'b0;
         done                  <= 1'b0;
         float_out             <= '0;
         float_out_overflow    <= 1'b0;
         float_out_underflow   <= 1'b0;
         float_out_div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sign  <= float_a[W-1] ^ float_b[W-1];
                  ea    <= float_a[W-2:MAN_W];
                  eb    <= float_b[W-2:MAN_W];
                  b_man <= {1'b1, float_b[MAN_W-1:0]};
                  rem   <= {2'b01, float_a[MAN_W-1:0]};
                  q     <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            DIV: begin
               q   <= {q[MAN_W:0], ge};
               rem <= ge ? {rem_sub[MAN_W:0], 1'b0} : {rem[MAN_W:0], 1'b0};
               cnt <= cnt + 1'b1;
            end
            NORM: begin
               float_out             <= res_word;
               float_out_overflow    <= res_ov;
               float_out_underflow   <= res_uf;
               float_out_div_by_zero <= res_dz;
               done                  <= 1'b1;
               busy                  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_float_divider.sv
// tb/tb_float_divider.sv - directed-vector bench for float_divider
module tb_float_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [23:0] float_a, float_b;
   logic        busy, done;
   logic [23:0] float_out;
   logic        float_out_overflow, float_out_underflow, float_out_div_by_zero;

   int n_cmp = 0;
   int n_err = 0;

   float_divider dut (
      .clk                   (clk),
      .rst                   (rst),
      .start                 (start),
      .float_a               (float_a),
      .float_b               (float_b),
      .busy                  (busy),
      .done                  (done),
      .float_out             (float_out),
      .float_out_overflow    (float_out_overflow),
      .float_out_underflow   (float_out_underflow),
      .float_out_div_by_zero (float_out_div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic run_op(input string name, input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] exp_out, input logic exp_ov, input logic exp_uf,
                         input logic exp_dz, input int pulse_at);
      int  k;
      bit  got;
      logic [23:0] held;
      @(negedge clk);
      start = 1'b1; float_a = a; float_b = b;
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_after_accept got=%b want=1", name, busy); end
      start = 1'b0; float_a = 24'h5A5A5A; float_b = 24'h3C1234;
      k = 0; got = 0;
      while (k < 40 && !got) begin
         @(posedge clk); #1;
         k++;
         if (done) got = 1;
         else if (k == pulse_at) begin
            start = 1'b1; float_a = 24'h418000; float_b = 24'h400000;
         end else begin
            start = 1'b0; float_a = 24'h5A5A5A ^ 24'(k); float_b = 24'h3C1234;
         end
      end
      start = 1'b0;
      n_cmp++;
      if (!got || k != 19) begin n_err++; $display("FAIL %s latency got=%0d done_seen=%0d want=19", name, k, got); end
      n_cmp++;
      if (float_out !== exp_out) begin n_err++; $display("FAIL %s float_out got=%h want=%h", name, float_out, exp_out); end
      n_cmp++;
      if ({float_out_overflow, float_out_underflow, float_out_div_by_zero} !== {exp_ov, exp_uf, exp_dz}) begin
         n_err++;
         $display("FAIL %s flags ov/uf/dz got=%b%b%b want=%b%b%b", name, float_out_overflow,
                  float_out_underflow, float_out_div_by_zero, exp_ov, exp_uf, exp_dz);
      end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_at_done got=%b want=0", name, busy); end
      held = float_out;
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0 || float_out !== exp_out) begin
         n_err++; $display("FAIL %s hold done=%b out=%h want done=0 out=%h", name, done, float_out, exp_out);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; float_a = 24'h0; float_b = 24'h0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, float_out, float_out_overflow, float_out_underflow, float_out_div_by_zero} !== 29'h0) begin
         n_err++; $display("FAIL reset_state busy=%b done=%b out=%h want all 0", busy, done, float_out);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_basic();
      run_op("six_by_two", 24'h418000, 24'h400000, 24'h408000, 0, 0, 0, 0);
      run_op("one_by_1p5", 24'h3F0000, 24'h3F8000, 24'h3E5555, 0, 0, 0, 0);
      run_op("neg_one",    24'hBF0000, 24'h3F0000, 24'hBF0000, 0, 0, 0, 0);
   endtask

   task automatic test_special();
      run_op("overflow",  24'h7FFFFF, 24'h3E0000, 24'h7FFFFF, 1, 0, 0, 0);
      run_op("underflow", 24'h010000, 24'h400000, 24'h000000, 0, 1, 0, 0);
      run_op("div_zero",  24'h3F0000, 24'h000000, 24'h7FFFFF, 1, 0, 1, 0);
      run_op("zero_num",  24'h000000, 24'h3F0000, 24'h000000, 0, 0, 0, 0);
   endtask

   task automatic test_reset_mid_div();
      bit seen;
      run_op("pre_reset", 24'h418000, 24'h400000, 24'h408000, 0, 0, 0, 0);
      @(negedge clk);
      start = 1'b1; float_a = 24'h3F0000; float_b = 24'h3F8000;
      @(posedge clk); #1; start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, float_out, float_out_overflow, float_out_underflow, float_out_div_by_zero} !== 29'h0) begin
         n_err++; $display("FAIL reset_mid_div busy=%b done=%b out=%h want all 0", busy, done, float_out);
      end
      @(negedge clk); rst = 1'b0;
      seen = 0;
      repeat (25) begin @(posedge clk); #1; if (done) seen = 1; end
      n_cmp++;
      if (seen) begin n_err++; $display("FAIL reset_abort done_seen=1 want=0"); end
      run_op("post_reset", 24'h3F0000, 24'h3F8000, 24'h3E5555, 0, 0, 0, 0);
   endtask

   task automatic test_ignore_start();
      run_op("ignore_start", 24'h3F0000, 24'h3F8000, 24'h3E5555, 0, 0, 0, 5);
   endtask

   task automatic test_back_to_back();
      logic [23:0] va [4];
      logic [23:0] vb [4];
      logic [23:0] vo [4];
      logic [2:0]  vf [4];
      int nd;
      va[0] = 24'h418000; vb[0] = 24'h400000; vo[0] = 24'h408000; vf[0] = 3'b000;
      va[1] = 24'h3F0000; vb[1] = 24'h3F8000; vo[1] = 24'h3E5555; vf[1] = 3'b000;
      va[2] = 24'hBF0000; vb[2] = 24'h3F0000; vo[2] = 24'hBF0000; vf[2] = 3'b000;
      va[3] = 24'h3F0000; vb[3] = 24'h000000; vo[3] = 24'h7FFFFF; vf[3] = 3'b101;
      nd = 0;
      @(negedge clk);
      start = 1'b1; float_a = va[0]; float_b = vb[0];
      for (int c = 0; c <= 80; c++) begin
         @(posedge clk); #1;
         if (done) nd++;
         if (c % 20 == 19) begin
            n_cmp++;
            if (done !== 1'b1 || float_out !== vo[c/20] ||
                {float_out_overflow, float_out_underflow, float_out_div_by_zero} !== vf[c/20]) begin
               n_err++;
               $display("FAIL b2b_%0d done=%b out=%h flags=%b%b%b want done=1 out=%h flags=%b", c/20, done,
                        float_out, float_out_overflow, float_out_underflow, float_out_div_by_zero,
                        vo[c/20], vf[c/20]);
            end
         end
         if ((c + 1) % 20 == 0 && (c + 1) / 20 < 4) begin
            float_a = va[(c+1)/20]; float_b = vb[(c+1)/20];
         end else begin
            float_a = 24'h5A0000 ^ 24'(c); float_b = 24'h3C1234 + 24'(c);
         end
      end
      start = 1'b0;
      n_cmp++;
      if (nd != 4) begin n_err++; $display("FAIL b2b_count got=%0d want=4", nd); end
      repeat (25) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_special();
      test_reset_mid_div();
      test_ignore_start();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
